// File: rtl/mem_fill_engine.sv
// Memory initialiser: writes DEPTH words from address 0 with a run-time selectable pattern.
// Optional read-back check of the filled words is compiled in with MEM_FILL_ENGINE_VERIFY_EN.
module mem_fill_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [DATA_W-1:0] q,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // One extra counter bit lets DEPTH == 2**ADDR_W terminate without wrapping.
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_VERIFY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wren_q, wren_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    function automatic logic [DATA_W-1:0] pattern(
        input logic [1:0]        m,
        input logic [DATA_W-1:0] fv,
        input logic [CW-1:0]     k
    );
        logic [CW-1:0] desc;
        desc = LAST - k;
        case (m)
            2'd0:    pattern = DATA_W'(k);
            2'd1:    pattern = fv;
            2'd2:    pattern = DATA_W'(desc);
            default: pattern = DATA_W'(k) ^ fv;
        endcase
    endfunction

`ifdef MEM_FILL_ENGINE_VERIFY_EN
    localparam logic [CW-1:0] ENDV = CW'(DEPTH);

    logic              error_q, error_d;
    logic              vld_p1_q, vld_p1_d;
    logic [DATA_W-1:0] exp_p1_q, exp_p1_d;
`else
    logic unused_q;
    assign unused_q = ^q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        fill_d    = fill_q;
        address_d = address_q;
        data_d    = data_q;
        wren_d    = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
`ifdef MEM_FILL_ENGINE_VERIFY_EN
        // Read issued last cycle returns now; compare against its expected word.
        error_d  = error_q | (vld_p1_q && (q != exp_p1_q));
        vld_p1_d = (state_q == S_VERIFY) && start && (cnt_q != ENDV);
        exp_p1_d = pattern(mode_q, fill_q, cnt_q);
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d    = mode;
                    fill_d    = fill_value;
                    cnt_d     = '0;
                    address_d = '0;
                    data_d    = pattern(mode, fill_value, '0);
                    wren_d    = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = S_FILL;
`ifdef MEM_FILL_ENGINE_VERIFY_EN
                    error_d   = 1'b0;
`endif
                end
            end

            S_FILL: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST) begin
`ifdef MEM_FILL_ENGINE_VERIFY_EN
                    state_d   = S_VERIFY;
                    cnt_d     = '0;
                    address_d = '0;
                    busy_d    = 1'b1;
`else
                    state_d   = S_DONE;
                    done_d    = 1'b1;
`endif
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    address_d = ADDR_W'(cnt_q + 1'b1);
                    data_d    = pattern(mode_q, fill_q, cnt_q + 1'b1);
                    wren_d    = 1'b1;
                    busy_d    = 1'b1;
                end
            end

`ifdef MEM_FILL_ENGINE_VERIFY_EN
            S_VERIFY: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (cnt_q == ENDV) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    // Final cycle only waits for the last read to return.
                    busy_d = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q != LAST) begin
                        address_d = ADDR_W'(cnt_q + 1'b1);
                    end
                end
            end
`endif

            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mode_q    <= '0;
            fill_q    <= '0;
            address_q <= '0;
            data_q    <= '0;
            wren_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            fill_q    <= fill_d;
            address_q <= address_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef MEM_FILL_ENGINE_VERIFY_EN
    // Stage p1: expected word aligned with the RAM read latency.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            error_q  <= 1'b0;
            vld_p1_q <= 1'b0;
        end else begin
            error_q  <= error_d;
            vld_p1_q <= vld_p1_d;
        end
    end

    always_ff @(posedge clk) begin
        exp_p1_q <= exp_p1_d;
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign address = address_q;
    assign data    = data_q;
    assign wren    = wren_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
